// File: rtl/pin_event_pkg.sv
// pin_event_pkg: shared widths and frame packing for pin_event_spi_reporter.
//   PIN_W_DEF   default monitored pin width
//   TS_W_DEF    default timestamp width (multiple of 8)
//   FRAME_W     bits per SPI frame (pin byte + timestamp)
//   build_frame packs {pins, ts bytes least-significant first}, each byte MSB-first
package pin_event_pkg;

  localparam int unsigned PIN_W_DEF = 8;
  localparam int unsigned TS_W_DEF  = 32;
  localparam int unsigned FRAME_W   = PIN_W_DEF + TS_W_DEF;
  localparam int unsigned TS_BYTES  = TS_W_DEF / 8;

  function automatic logic [FRAME_W-1:0] build_frame(input logic [PIN_W_DEF-1:0] pins,
                                                      input logic [TS_W_DEF-1:0]  ts);
    logic [FRAME_W-1:0] f;
    f = '0;
    f[FRAME_W-1 -: PIN_W_DEF] = pins;
    // Byte i of the timestamp lands in slot i counted from the top of the ts field.
    for (int unsigned i = 0; i < TS_BYTES; i++) begin
      f[TS_W_DEF-1-8*i -: 8] = ts[8*i +: 8];
    end
    return f;
  endfunction

endpackage

// File: rtl/spi_tx_shifter.sv
// spi_tx_shifter: slave-only SPI mode 0 transmitter for fixed-length frames.
//   clk      in   system clock
//   rst      in   asynchronous active-low reset
//   spi_clk  in   SPI clock from master, oversampled in the clk domain
//   frame    in   live frame; captured on the first rising edge of a transfer
//   miso     out  serial data, MSB first, changes after spi_clk falls
module spi_tx_shifter #(
  parameter int unsigned FRAME_W = 40
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               spi_clk,
  input  logic [FRAME_W-1:0] frame,
  output logic               miso
);

  localparam int unsigned CNT_W = $clog2(FRAME_W);
  localparam logic [CNT_W-1:0] LastBit = CNT_W'(FRAME_W - 1);

  logic               spi_q;
  logic [CNT_W-1:0]   bit_cnt_q, bit_cnt_d;
  logic [FRAME_W-1:0] shift_q, shift_d;
  logic               rise, fall, idle;

  assign rise = spi_clk & ~spi_q;
  assign fall = ~spi_clk & spi_q;
  assign idle = (bit_cnt_q == '0);

  always_comb begin
    bit_cnt_d = bit_cnt_q;
    shift_d   = shift_q;
    if (rise) begin
      // Frame is frozen at transfer start so later events cannot tear it.
      if (idle) shift_d = frame;
      bit_cnt_d = (bit_cnt_q == LastBit) ? '0 : bit_cnt_q + CNT_W'(1);
    end else if (fall && !idle) begin
      shift_d = shift_q << 1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      spi_q     <= 1'b0;
      bit_cnt_q <= '0;
      shift_q   <= '0;
    end else begin
      spi_q     <= spi_clk;
      bit_cnt_q <= bit_cnt_d;
      shift_q   <= shift_d;
    end
  end

  // While idle the master sees the newest event's first bit without waiting for a load.
  assign miso = idle ? frame[FRAME_W-1] : shift_q[FRAME_W-1];

endmodule

// File: rtl/pin_event_spi_reporter.sv
// pin_event_spi_reporter: timestamps changes on a pin port, reports the latest over SPI.
//   clk         in   system clock
//   rst         in   asynchronous active-low reset
//   spi_clk     in   SPI clock from master (mode 0, idles low)
//   mosi        in   SPI data from master, ignored
//   miso        out  SPI data to master: {pins, ts bytes LSB-byte first}
//   pin_values  in   monitored pins
// Build option: define PIN_SYNC_EN to pass pins through a 2-flop synchronizer; the
// recorded timestamp is then backdated by 2 to the cycle the pins were first sampled.
// PIN_W/TS_W must match the pin_event_pkg defaults, which size the frame packer.
import pin_event_pkg::*;

module pin_event_spi_reporter #(
  parameter int unsigned PIN_W = PIN_W_DEF,
  parameter int unsigned TS_W  = TS_W_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             spi_clk,
  input  logic             mosi,
  output logic             miso,
  input  logic [PIN_W-1:0] pin_values
);

  logic [TS_W-1:0]    counter_q;
  logic [PIN_W-1:0]   pin_prev_q;
  logic [PIN_W-1:0]   event_pins_q;
  logic [TS_W-1:0]    event_ts_q;
  logic [PIN_W-1:0]   pins_s;
  logic [TS_W-1:0]    ts_s;
  logic [FRAME_W-1:0] frame;
  logic               unused_mosi;

  assign unused_mosi = mosi;

`ifdef PIN_SYNC_EN
  logic [PIN_W-1:0] sync1_q, sync2_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync1_q <= '0;
      sync2_q <= '0;
    end else begin
      sync1_q <= pin_values;
      sync2_q <= sync1_q;
    end
  end

  assign pins_s = sync2_q;
  assign ts_s   = counter_q - TS_W'(2);
`else
  assign pins_s = pin_values;
  assign ts_s   = counter_q;
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      counter_q    <= '0;
      pin_prev_q   <= '0;
      event_pins_q <= '0;
      event_ts_q   <= '0;
    end else begin
      counter_q  <= counter_q + TS_W'(1);
      pin_prev_q <= pins_s;
      if (pins_s != pin_prev_q) begin
        event_pins_q <= pins_s;
        event_ts_q   <= ts_s;
      end
    end
  end

  assign frame = build_frame(event_pins_q, event_ts_q);

  spi_tx_shifter #(
    .FRAME_W (FRAME_W)
  ) u_spi_tx_shifter (
    .clk     (clk),
    .rst     (rst),
    .spi_clk (spi_clk),
    .frame   (frame),
    .miso    (miso)
  );

endmodule

// File: tb/tb_pin_event_spi_reporter.sv
// tb_pin_event_spi_reporter: randomized self-checking bench. The reference keeps the latest
// event as (pins, cycle count when the pins were driven) and predicts each 40-bit frame.
module tb_pin_event_spi_reporter;

`ifdef PIN_SYNC_EN
  localparam int LAT = 3;
`else
  localparam int LAT = 1;
`endif

  logic       clk = 1'b0;
  logic       rst;
  logic       spi_clk;
  logic       mosi;
  logic       miso;
  logic [7:0] pin_values;

  int errors = 0;
  int checks = 0;

  // Reference state.
  logic [31:0] m_cnt;
  logic [7:0]  cur_pins;
  logic [7:0]  exp_pins;
  logic [31:0] exp_ts;

  always #5 clk = ~clk;

  pin_event_spi_reporter dut (
    .clk        (clk),
    .rst        (rst),
    .spi_clk    (spi_clk),
    .mosi       (mosi),
    .miso       (miso),
    .pin_values (pin_values)
  );

  // Elapsed clock edges since reset release = DUT counter value at the next edge.
  always @(posedge clk or negedge rst) begin
    if (!rst) m_cnt <= 32'd0;
    else      m_cnt <= m_cnt + 32'd1;
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [39:0] frame_of(input logic [7:0] p, input logic [31:0] t);
    return {p, t[7:0], t[15:8], t[23:16], t[31:24]};
  endfunction

  // Drive pins at the current point (a negedge) and update the reference event.
  task automatic drive_pins(input logic [7:0] v);
    if (v !== cur_pins) begin
      exp_pins = v;
      exp_ts   = m_cnt;
      cur_pins = v;
    end
    pin_values = v;
  endtask

  task automatic set_pins(input logic [7:0] v);
    @(negedge clk);
    drive_pins(v);
  endtask

  task automatic do_reset();
    spi_clk    = 1'b0;
    pin_values = 8'h00;
    rst        = 1'b0;
    cur_pins   = 8'h00;
    exp_pins   = 8'h00;
    exp_ts     = 32'd0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
  endtask

  // Clock out one frame; optionally change pins after bit chg_bit or reset at bit rst_bit.
  task automatic read_frame(output logic [39:0] data, input int chg_bit,
                            input logic [7:0] chg_val, input int rst_bit, output bit aborted);
    data    = '0;
    aborted = 1'b0;
    for (int b = 0; b < 40; b++) begin
      repeat (3) @(negedge clk);
      data    = {data[38:0], miso};
      mosi    = 1'($urandom);
      spi_clk = 1'b1;
      if (b == rst_bit) begin
        do_reset();
        aborted = 1'b1;
        return;
      end
      repeat (3) @(negedge clk);
      spi_clk = 1'b0;
      if (b == chg_bit) drive_pins(chg_val);
    end
    repeat (3) @(negedge clk);
  endtask

  logic [39:0] data;
  logic [39:0] snap;
  bit          ab;

  initial begin
    spi_clk    = 1'b0;
    mosi       = 1'b0;
    pin_values = 8'h00;
    rst        = 1'b1;
    cur_pins   = 8'h00;
    exp_pins   = 8'h00;
    exp_ts     = 32'd0;
    #2 rst = 1'b0;
    repeat (2) @(negedge clk);
    check("miso_in_reset", 64'(miso), 64'd0);
    rst = 1'b1;
    @(posedge clk);
    #1;
    check("counter_after_release", 64'(dut.counter_q), 64'd1);
    check("miso_after_release", 64'(miso), 64'd0);

    read_frame(data, -1, 8'h00, -1, ab);
    check("frame_no_event", 64'(data), 64'(frame_of(8'h00, 32'd0)));

    // First event 0xD2 at T.
    set_pins(8'hD2);
    repeat (LAT) @(negedge clk);
    check("idle_miso_latency", 64'(miso), 64'd1);
    repeat (2) @(negedge clk);
    read_frame(data, -1, 8'h00, -1, ab);
    check("pin_byte_d2", 64'(data[39:32]), 64'hD2);
    check("frame_d2", 64'(data), 64'(frame_of(8'hD2, exp_ts)));

    // Change to 0x2D right after the pin byte: this frame still carries T.
    snap = frame_of(exp_pins, exp_ts);
    read_frame(data, 7, 8'h2D, -1, ab);
    check("frame_mid_change", 64'(data), 64'(snap));
    check("idle_miso_2d", 64'(miso), 64'd0);
    read_frame(data, -1, 8'h00, -1, ab);
    check("frame_2d", 64'(data), 64'(frame_of(8'h2D, exp_ts)));
    read_frame(data, -1, 8'h00, -1, ab);
    check("frame_2d_repeat", 64'(data), 64'(frame_of(8'h2D, exp_ts)));

    // Reset mid-frame, then a fresh event.
    read_frame(data, -1, 8'h00, 17, ab);
    check("aborted", 64'(ab), 64'd1);
    check("miso_after_abort", 64'(miso), 64'd0);
    set_pins(8'h01);
    repeat (LAT + 2) @(negedge clk);
    read_frame(data, -1, 8'h00, -1, ab);
    check("frame_after_abort", 64'(data), 64'(frame_of(8'h01, exp_ts)));

    // Randomized rounds.
    for (int r = 0; r < 24; r++) begin
      logic [7:0] v;
      logic [7:0] cv;
      int         cb;
      v  = ($urandom_range(3) == 0) ? cur_pins : 8'($urandom);
      cv = 8'($urandom);
      cb = ($urandom_range(2) == 0) ? int'($urandom_range(39)) : -1;
      set_pins(v);
      repeat (LAT) @(negedge clk);
      check($sformatf("rnd%0d_idle_miso", r), 64'(miso), 64'(exp_pins[7]));
      repeat (2) @(negedge clk);
      snap = frame_of(exp_pins, exp_ts);
      read_frame(data, cb, cv, -1, ab);
      check($sformatf("rnd%0d_frame", r), 64'(data), 64'(snap));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
